// File: rtl/ring_sched_pkg.sv
// Shared definitions for the ring scheduler: FSM state encoding and default sizing.
package ring_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or above the token index, wrapping mod N.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    token,
  output logic [N-1:0]    pick_onehot,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_valid
);

  logic [ID_W-1:0] start_id;
  int              idx;

  always_comb begin
    start_id = '0;
    idx      = 0;
    pick_id  = '0;
    for (int j = 0; j < N; j++) begin
      if (token[j]) start_id = ID_W'(j);
    end
    // Walk from the farthest ring position back to the token so the closest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start_id) + k) % N;
      if (req[idx]) pick_id = ID_W'(idx);
    end
    pick_valid  = |req;
    pick_onehot = pick_valid ? (N'(1) << pick_id) : '0;
  end

endmodule

// File: rtl/ring_scheduler.sv
// Round-robin scheduler: one-hot rotating token, bounded grant hold, one dead GAP cycle between grants.
// Handshake: req[i] is a level; the owner keeps it high to keep gnt[i], and gnt[i] is the only acknowledge.
module ring_scheduler
  import ring_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    token,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [N-1:0]    token_q, token_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [N-1:0]    pick_onehot;
  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
  logic            release_now;
  logic [ID_W-1:0] next_id;

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req         (req),
    .token       (token_q),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .pick_valid  (pick_valid)
  );

  assign release_now = !req[gnt_id_q] || (hold_q == CNT_W'(MAX_HOLD - 1));
  assign next_id     = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    token_d  = token_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          gnt_d    = pick_onehot;
          gnt_id_d = pick_id;
          hold_d   = '0;
          state_d  = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d   = '0;
          token_d = N'(1) << next_id;
          state_d = GAP;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      token_q  <= N'(1);
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      token_q  <= token_d;
      hold_q   <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign token     = token_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ring_scheduler.sv
// Directed bench for ring_scheduler (N=4, MAX_HOLD=4): vector table plus hand-written corner sequences.
module tb_ring_scheduler;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int WAIT_MAX = (N - 1) * (MAX_HOLD + 1) + 1;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] token;
  logic       busy;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] tok;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  ring_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .token     (token),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] et,
                           input logic [1:0] ei, input logic eb);
    check({tag, ".gnt"},    32'(gnt),    32'(eg));
    check({tag, ".token"},  32'(token),  32'(et));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(ei));
    check({tag, ".busy"},   32'(busy),   32'(eb));
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [3:0] t,
                              input logic [1:0] i, input logic b);
    vec_t v;
    v.req = r; v.gnt = g; v.tok = t; v.id = i; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int         wait_c[4];
  int         run_len;
  logic [3:0] prev_gnt;
  logic [3:0] req_r;

  initial begin
    rst = 1'b0;
    req = 4'b1111;

    // reset held for 3 cycles with every requester active
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("reset", 4'b0000, 4'b0001, 2'd0, 1'b0);
      check("reset.state", 32'(state_dbg), 32'd0);
    end
    rst = 1'b1;

    // single requester 2: four grant cycles, GAP, re-grant, then early drop to IDLE
    for (int c = 0; c < 4; c++) add(4'b0100, 4'b0100, 4'b0001, 2'd2, 1'b1);
    add(4'b0100, 4'b0000, 4'b1000, 2'd2, 1'b1);
    add(4'b0100, 4'b0100, 4'b1000, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, 4'b1000, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, 4'b1000, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 4'b1000, 2'd2, 1'b0);
    // full load starting with the token at requester 3
    begin
      int order[5] = '{3, 0, 1, 2, 3};
      for (int k = 0; k < 5; k++) begin
        logic [3:0] oh;
        logic [3:0] nxt;
        oh  = 4'(1) << order[k];
        nxt = 4'(1) << ((order[k] + 1) % 4);
        for (int c = 0; c < 4; c++) add(4'b1111, oh, oh, 2'(order[k]), 1'b1);
        add(4'b1111, 4'b0000, nxt, 2'(order[k]), 1'b1);
      end
    end

    for (int v = 0; v < vecs.size(); v++) begin
      req = vecs[v].req;
      step();
      check_all($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].tok, vecs[v].id, vecs[v].busy);
    end

    // early release and skip: token 0001, req 1010
    do_reset();
    req = 4'b1010;
    step();
    check_all("skip.g1", 4'b0010, 4'b0001, 2'd1, 1'b1);
    step();
    check_all("skip.g2", 4'b0010, 4'b0001, 2'd1, 1'b1);
    req = 4'b1000;
    step();
    check_all("skip.rel", 4'b0000, 4'b0100, 2'd1, 1'b1);
    step();
    check_all("skip.next", 4'b1000, 4'b0100, 2'd3, 1'b1);

    // asynchronous reset in the middle of a grant
    do_reset();
    req = 4'b0100;
    step();
    check_all("async.pre", 4'b0100, 4'b0001, 2'd2, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all("async.rst", 4'b0000, 4'b0001, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_all("async.regrant", 4'b0100, 4'b0001, 2'd2, 1'b1);

    // random held requests: invariants, hold bound and wait bound
    do_reset();
    req_r = 4'b0000;
    req = req_r;
    run_len = 0;
    prev_gnt = 4'b0000;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      check("inv.gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv.token_onehot", 32'($onehot(token)), 32'd1);
      if (gnt != 4'b0000 && gnt == prev_gnt) run_len++;
      else if (gnt != 4'b0000) run_len = 1;
      else run_len = 0;
      check("inv.hold_len_ok", 32'(run_len <= MAX_HOLD), 32'd1);
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) wait_c[i] = 0;
        else if (req_r[i]) wait_c[i]++;
        check($sformatf("inv.wait_ok%0d", i), 32'(wait_c[i] <= WAIT_MAX), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(0, 3) == 0) req_r[i] = 1'b0;
        end else if (!req_r[i]) begin
          if ($urandom_range(0, 3) == 0) req_r[i] = 1'b1;
        end
      end
      req = req_r;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
